de_decode_sb_stage: RTL and testbench
=====================================

Name: de_decode_sb_stage

Overview:
- Decode stage directly downstream of the fetch stage. Consumes the FE pipeline latch and produces the DE pipeline latch for AGEX.
- Decodes RV32I fields and generates immediates.
- Owns the 32x32 register file.
- Tracks in-flight register writes with a per-register scoreboard and generates the FE stall.
- Carries the branch-predictor metadata (PHT index, predicted next PC) through to AGEX.

Parameters:
- XLEN, 32, data and PC width
- NREGS, 32, architectural registers; x0 is hardwired to zero
- SB_CNT_W, 2, width of each per-register pending-write counter (max 3 in flight: AGEX, MEM, WB)
- PHT_IDX_W, 8, width of the PHT index carried through

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- fe_latch_in  in  1+32+XLEN*3+PHT_IDX_W+XLEN  {valid, inst, pc, pcplus, inst_count, pht_index, pred_next_pc}
- br_mispred_agex  in  1  AGEX mispredict; flush DE
- wb_wr_en  in  1  WB retires a register write
- wb_wr_reg  in  5  WB destination register
- wb_wr_data  in  XLEN  WB write data
- stall_to_fe  out  1  holds the FE PC and the FE latch
- de_latch_out  out  DE_LATCH_W  {valid, inst, pc, pcplus, inst_count, op_class[3:0], rs1_val, rs2_val, imm, rd, wr_rd, pht_index, pred_next_pc}

Behaviour:
- **Reset** (reset=0, asynchronous): DE latch all-zero (valid=0), all scoreboard counters 0, all register-file entries 0. With valid=0, stall_to_fe=0.
- **Decode** (combinational, from fe_latch_in):
  - Extract rs1=inst[19:15], rs2=inst[24:20], rd=inst[11:7].
  - op_class covers: ALU-R, ALU-I, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, ILLEGAL.
  - use_rs1 / use_rs2 / wr_rd are derived from op_class.
  - wr_rd is forced to 0 when rd==0.
- **Immediates**: I, S, B, U and J formats, sign-extended to XLEN. The B and J low bit is 0.
- **Register read**:
  - x0 always reads 0.
  - If wb_wr_en and wb_wr_reg==rsN and rsN!=0, the read bypasses wb_wr_data in the same cycle.
  - The register write takes effect at the clock edge; writes to x0 are ignored.
- **Hazard per source**: hazN = valid & use_rsN & rsN!=0 & (cnt[rsN]!=0) & !(wb_wr_en & wb_wr_reg==rsN & cnt[rsN]==1).
- **Stall**: stall_to_fe = haz1 | haz2, with latency 0.
- **Issue**: issue = valid & !stall_to_fe & !br_mispred_agex.
- **Scoreboard update** (at posedge):
  - inc = issue & wr_rd (on rd).
  - dec = wb_wr_en & wb_wr_reg!=0 (on wb_wr_reg).
  - inc and dec on the same register: counter unchanged.
  - Increment at the maximum value (3) is a protocol error: assertion fires and the counter saturates.
  - Decrement at 0 is a protocol error: assertion fires and the counter holds 0.
- **DE latch update** (at posedge, priority order):
  1. br_mispred_agex → all-zero bubble.
  2. stall_to_fe → all-zero bubble (FE holds its latch).
  3. Otherwise → decoded contents.
- **Flush rules**:
  - A mispredict in the same cycle as a stall: the flush wins, there is no increment, and stall_to_fe is still driven so FE and flush priorities are consistent (FE gives mispredict priority).
  - The scoreboard is never rolled back on flush: only the DE instruction is younger than the resolving branch, and it never incremented.
- **Invalid FE input** (valid=0): no hazard, no increment, bubble out.
- **Reset mid-operation**: all in-flight counts are discarded. Downstream stages are reset by the same signal, so there are no stale decrements.

Decomposition:
- Shared package de_pkg holds:
  - op_class enum
  - RV32I opcode constants
  - instruction field bit positions
  - FE/DE latch field widths and offsets, including DE_LATCH_W
- Sub-module de_scoreboard holds the counter array. Inputs: inc/inc_reg, dec/dec_reg, two query regs, wb-bypass info. Outputs: haz1, haz2.

Test Plan:
1. **Reset**: reset low mid-stream while counters are nonzero → de_latch_out=0 and stall_to_fe=0 immediately; after release, counters read 0, so a dependent instruction issues with no stall.
2. **RAW dependency**: addi x5,x0,7 then add x6,x5,x5 → stall_to_fe=1 for exactly 2 cycles (producer in AGEX, then MEM). The third cycle issues with the WB bypass, and the DE latch carries rs1_val=rs2_val=7.
3. **x0 destination**: addi x0,x0,1 then add x1,x0,x0 → no stall, rs1_val=0, scoreboard unchanged.
4. **Mispredict while stalled**: dependent stalled plus br_mispred_agex=1 → next DE latch valid=0, no counter increment, and WB later drives the counter to 0 with no underflow assertion.
5. **B-immediate**: inst 0xFE000EE3 (beq x0,x0,-4) → op_class=BRANCH, imm=0xFFFFFFFC, wr_rd=0.
6. **Simultaneous inc/dec**: issue rd=x3 while WB retires x3 with cnt[x3]=1 → cnt[x3] stays 1, and a following reader of x3 stalls.

Source files
------------

// File: rtl/de_decode_sb_stage_pkg.sv
// Shared decode-stage types: op classes, RV32I opcodes, field positions and
// the FE/DE pipeline latch layouts.
package de_pkg;

  localparam int XLEN_DFLT      = 32;
  localparam int NREGS_DFLT     = 32;
  localparam int SB_CNT_W_DFLT  = 2;
  localparam int PHT_IDX_W_DFLT = 8;
  localparam int REG_W          = 5;

  typedef enum logic [3:0] {
    OC_ILLEGAL = 4'd0,
    OC_ALU_R   = 4'd1,
    OC_ALU_I   = 4'd2,
    OC_LOAD    = 4'd3,
    OC_STORE   = 4'd4,
    OC_BRANCH  = 4'd5,
    OC_JAL     = 4'd6,
    OC_JALR    = 4'd7,
    OC_LUI     = 4'd8,
    OC_AUIPC   = 4'd9
  } op_class_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam int OPC_LSB = 0;
  localparam int RD_LSB  = 7;
  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;

  typedef struct packed {
    logic                      valid;
    logic [31:0]               inst;
    logic [XLEN_DFLT-1:0]      pc;
    logic [XLEN_DFLT-1:0]      pcplus;
    logic [XLEN_DFLT-1:0]      inst_count;
    logic [PHT_IDX_W_DFLT-1:0] pht_index;
    logic [XLEN_DFLT-1:0]      pred_next_pc;
  } fe_latch_t;

  typedef struct packed {
    logic                      valid;
    logic [31:0]               inst;
    logic [XLEN_DFLT-1:0]      pc;
    logic [XLEN_DFLT-1:0]      pcplus;
    logic [XLEN_DFLT-1:0]      inst_count;
    op_class_e                 op_class;
    logic [XLEN_DFLT-1:0]      rs1_val;
    logic [XLEN_DFLT-1:0]      rs2_val;
    logic [XLEN_DFLT-1:0]      imm;
    logic [REG_W-1:0]          rd;
    logic                      wr_rd;
    logic [PHT_IDX_W_DFLT-1:0] pht_index;
    logic [XLEN_DFLT-1:0]      pred_next_pc;
  } de_latch_t;

  localparam int FE_LATCH_W   = $bits(fe_latch_t);
  localparam int DE_LATCH_W   = $bits(de_latch_t);
  localparam int FE_VALID_OFS = FE_LATCH_W - 1;
  localparam int DE_VALID_OFS = DE_LATCH_W - 1;

endpackage

// File: rtl/de_decode_sb_stage_if.sv
// FE->DE->AGEX latch bus plus the WB write port and mispredict flush.
interface de_decode_sb_stage_if;
  import de_pkg::*;

  logic [FE_LATCH_W-1:0] fe_latch_in;
  logic                  br_mispred_agex;
  logic                  wb_wr_en;
  logic [REG_W-1:0]      wb_wr_reg;
  logic [XLEN_DFLT-1:0]  wb_wr_data;
  logic                  stall_to_fe;
  logic [DE_LATCH_W-1:0] de_latch_out;

  modport master (
    output fe_latch_in, br_mispred_agex, wb_wr_en, wb_wr_reg, wb_wr_data,
    input  stall_to_fe, de_latch_out
  );

  modport slave (
    input  fe_latch_in, br_mispred_agex, wb_wr_en, wb_wr_reg, wb_wr_data,
    output stall_to_fe, de_latch_out
  );
endinterface

// File: rtl/de_decode_sb_stage_scoreboard.sv
// Per-register pending-write counters and source hazard detection.
module de_scoreboard #(
  parameter int NREGS    = 32,
  parameter int SB_CNT_W = 2,
  parameter int REG_W    = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic [REG_W-1:0] inc_reg,
  input  logic             dec,
  input  logic [REG_W-1:0] dec_reg,
  input  logic             q1_en,
  input  logic [REG_W-1:0] q1_reg,
  input  logic             q2_en,
  input  logic [REG_W-1:0] q2_reg,
  input  logic             byp_en,
  input  logic [REG_W-1:0] byp_reg,
  output logic             haz1,
  output logic             haz2
);

  localparam logic [SB_CNT_W-1:0] CNT_MAX = '1;
  localparam logic [SB_CNT_W-1:0] CNT_ONE = SB_CNT_W'(1);

  logic [NREGS-1:0][SB_CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        if (inc && inc_reg == REG_W'(r) && !(dec && dec_reg == REG_W'(r))) begin
          if (cnt[r] != CNT_MAX) cnt[r] <= cnt[r] + CNT_ONE;
        end else if (dec && dec_reg == REG_W'(r) && !(inc && inc_reg == REG_W'(r))) begin
          if (cnt[r] != '0) cnt[r] <= cnt[r] - CNT_ONE;
        end
      end
    end
  end

  // A last outstanding write retiring this cycle is covered by the WB bypass.
  function automatic logic hz(input logic en, input logic [REG_W-1:0] rs);
    return en && rs != '0 && cnt[rs] != '0 &&
           !(byp_en && byp_reg == rs && cnt[rs] == CNT_ONE);
  endfunction

  assign haz1 = hz(q1_en, q1_reg);
  assign haz2 = hz(q2_en, q2_reg);

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
    !(inc && !(dec && dec_reg == inc_reg) && cnt[inc_reg] == CNT_MAX));

  a_no_underflow: assert property (@(posedge clk) disable iff (!reset)
    !(dec && !(inc && inc_reg == dec_reg) && cnt[dec_reg] == '0));

endmodule

// File: rtl/de_decode_sb_stage.sv
// RV32I decode stage: field/immediate decode, register file, scoreboard stall
// and the DE pipeline latch toward AGEX.
module de_decode_sb_stage
  import de_pkg::*;
#(
  parameter int XLEN      = XLEN_DFLT,
  parameter int NREGS     = NREGS_DFLT,
  parameter int SB_CNT_W  = SB_CNT_W_DFLT,
  parameter int PHT_IDX_W = PHT_IDX_W_DFLT
) (
  input  logic clk,
  input  logic reset,
  de_decode_sb_stage_if.slave bus
);

  fe_latch_t              fe;
  de_latch_t              de_d, de_q;
  logic [31:0]            inst;
  logic [6:0]             opc;
  logic [REG_W-1:0]       rs1, rs2, rd;
  op_class_e              oc;
  logic                   use_rs1, use_rs2, wr_rd;
  logic [XLEN-1:0]        imm, rs1_val, rs2_val;
  logic [PHT_IDX_W-1:0]   pht_idx;
  logic                   haz1, haz2, stall, issue;
  logic [NREGS-1:0][XLEN-1:0] rf;

  assign fe      = fe_latch_t'(bus.fe_latch_in);
  assign inst    = fe.inst;
  assign opc     = inst[OPC_LSB +: 7];
  assign rs1     = inst[RS1_LSB +: REG_W];
  assign rs2     = inst[RS2_LSB +: REG_W];
  assign rd      = inst[RD_LSB +: REG_W];
  assign pht_idx = fe.pht_index;

  always_comb begin
    oc = OC_ILLEGAL;
    case (opc)
      OPC_OP:     oc = OC_ALU_R;
      OPC_OP_IMM: oc = OC_ALU_I;
      OPC_LOAD:   oc = OC_LOAD;
      OPC_STORE:  oc = OC_STORE;
      OPC_BRANCH: oc = OC_BRANCH;
      OPC_JAL:    oc = OC_JAL;
      OPC_JALR:   oc = OC_JALR;
      OPC_LUI:    oc = OC_LUI;
      OPC_AUIPC:  oc = OC_AUIPC;
      default:    oc = OC_ILLEGAL;
    endcase
    use_rs1 = oc inside {OC_ALU_R, OC_ALU_I, OC_LOAD, OC_STORE, OC_BRANCH, OC_JALR};
    use_rs2 = oc inside {OC_ALU_R, OC_STORE, OC_BRANCH};
    wr_rd   = (oc inside {OC_ALU_R, OC_ALU_I, OC_LOAD, OC_JAL, OC_JALR, OC_LUI, OC_AUIPC})
              && rd != '0;
  end

  always_comb begin
    imm = '0;
    case (oc)
      OC_ALU_I, OC_LOAD, OC_JALR:
        imm = XLEN'(signed'(inst[31:20]));
      OC_STORE:
        imm = XLEN'(signed'({inst[31:25], inst[11:7]}));
      OC_BRANCH:
        imm = XLEN'(signed'({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
      OC_LUI, OC_AUIPC:
        imm = XLEN'(signed'({inst[31:12], 12'b0}));
      OC_JAL:
        imm = XLEN'(signed'({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
      default: imm = '0;
    endcase
  end

  always_comb begin
    rs1_val = '0;
    if (rs1 == '0)                                     rs1_val = '0;
    else if (bus.wb_wr_en && bus.wb_wr_reg == rs1)     rs1_val = bus.wb_wr_data;
    else                                               rs1_val = rf[rs1];
    rs2_val = '0;
    if (rs2 == '0)                                     rs2_val = '0;
    else if (bus.wb_wr_en && bus.wb_wr_reg == rs2)     rs2_val = bus.wb_wr_data;
    else                                               rs2_val = rf[rs2];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                        rf <= '0;
    else if (bus.wb_wr_en && bus.wb_wr_reg != '0)      rf[bus.wb_wr_reg] <= bus.wb_wr_data;
  end

  de_scoreboard #(
    .NREGS(NREGS), .SB_CNT_W(SB_CNT_W), .REG_W(REG_W)
  ) u_sb (
    .clk     (clk),
    .reset   (reset),
    .inc     (issue && wr_rd),
    .inc_reg (rd),
    .dec     (bus.wb_wr_en && bus.wb_wr_reg != '0),
    .dec_reg (bus.wb_wr_reg),
    .q1_en   (fe.valid && use_rs1),
    .q1_reg  (rs1),
    .q2_en   (fe.valid && use_rs2),
    .q2_reg  (rs2),
    .byp_en  (bus.wb_wr_en),
    .byp_reg (bus.wb_wr_reg),
    .haz1    (haz1),
    .haz2    (haz2)
  );

  // Stall stays asserted under a flush; FE resolves mispredict first.
  assign stall = haz1 || haz2;
  assign issue = fe.valid && !stall && !bus.br_mispred_agex;

  always_comb begin
    de_d              = '0;
    de_d.valid        = 1'b1;
    de_d.inst         = inst;
    de_d.pc           = fe.pc;
    de_d.pcplus       = fe.pcplus;
    de_d.inst_count   = fe.inst_count;
    de_d.op_class     = oc;
    de_d.rs1_val      = rs1_val;
    de_d.rs2_val      = rs2_val;
    de_d.imm          = imm;
    de_d.rd           = rd;
    de_d.wr_rd        = wr_rd;
    de_d.pht_index    = pht_idx;
    de_d.pred_next_pc = fe.pred_next_pc;
  end

  // Flush, stall and invalid input all collapse to an all-zero bubble.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) de_q <= '0;
    else        de_q <= issue ? de_d : '0;
  end

  assign bus.de_latch_out = de_q;
  assign bus.stall_to_fe  = stall;

endmodule

// File: tb/tb_de_decode_sb_stage.sv
// Directed bench for the decode/scoreboard stage; the bench plays AGEX/MEM/WB.
module tb_de_decode_sb_stage;
  import de_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  de_decode_sb_stage_if ifc();

  de_decode_sb_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  de_latch_t de;
  assign de = de_latch_t'(ifc.de_latch_out);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic fe_drive(input logic [31:0] inst, input logic [31:0] pc, input logic v);
    fe_latch_t f;
    f.valid        = v;
    f.inst         = inst;
    f.pc           = pc;
    f.pcplus       = pc + 32'd4;
    f.inst_count   = pc >> 2;
    f.pht_index    = pc[9:2];
    f.pred_next_pc = pc + 32'd4;
    ifc.fe_latch_in = f;
  endtask

  task automatic wb(input logic en, input logic [4:0] r, input logic [31:0] d);
    ifc.wb_wr_en   = en;
    ifc.wb_wr_reg  = r;
    ifc.wb_wr_data = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    ifc.br_mispred_agex = 1'b0;
    fe_drive(32'h0, 32'h0, 1'b0);
    wb(1'b0, 5'd0, 32'h0);
    #12;
    chk("rst_latch", {63'd0, ifc.de_latch_out == '0}, 64'd1);
    chk("rst_stall", ifc.stall_to_fe, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // RAW: addi x5,x0,7 ; add x6,x5,x5
    fe_drive(32'h00700293, 32'h100, 1'b1);
    #1 chk("raw_p_stall", ifc.stall_to_fe, 64'd0);
    tick();
    chk("raw_p_valid", de.valid, 64'd1);
    chk("raw_p_oc", de.op_class, OC_ALU_I);
    chk("raw_p_imm", de.imm, 64'd7);
    chk("raw_p_rd", de.rd, 64'd5);
    chk("raw_p_wr", de.wr_rd, 64'd1);
    chk("raw_p_pht", de.pht_index, 64'h40);
    fe_drive(32'h00528333, 32'h104, 1'b1);
    #1 chk("raw_stall1", ifc.stall_to_fe, 64'd1);
    tick();
    chk("raw_bubble", de.valid, 64'd0);
    chk("raw_stall2", ifc.stall_to_fe, 64'd1);
    tick();
    wb(1'b1, 5'd5, 32'd7);
    #1 chk("raw_stall3", ifc.stall_to_fe, 64'd0);
    tick();
    chk("raw_c_valid", de.valid, 64'd1);
    chk("raw_c_oc", de.op_class, OC_ALU_R);
    chk("raw_c_rs1", de.rs1_val, 64'd7);
    chk("raw_c_rs2", de.rs2_val, 64'd7);
    chk("raw_c_pc", de.pc, 64'h104);
    wb(1'b0, 5'd0, 32'h0);

    // x0 destination: addi x0,x0,1 ; add x1,x0,x0
    fe_drive(32'h00100013, 32'h108, 1'b1);
    #1 chk("x0_stall_a", ifc.stall_to_fe, 64'd0);
    tick();
    chk("x0_wr", de.wr_rd, 64'd0);
    chk("x0_valid", de.valid, 64'd1);
    fe_drive(32'h000000B3, 32'h10C, 1'b1);
    #1 chk("x0_stall_b", ifc.stall_to_fe, 64'd0);
    tick();
    chk("x0_rs1", de.rs1_val, 64'd0);
    chk("x0_rd_wr", {de.rd, de.wr_rd}, {58'd0, 5'd1, 1'b1});

    // Invalid FE input while retiring x6 and x1
    fe_drive(32'h00528333, 32'h110, 1'b0);
    wb(1'b1, 5'd6, 32'd14);
    #1 chk("inv_stall", ifc.stall_to_fe, 64'd0);
    tick();
    chk("inv_bubble", {63'd0, ifc.de_latch_out == '0}, 64'd1);
    wb(1'b1, 5'd1, 32'd0);
    tick();
    wb(1'b0, 5'd0, 32'h0);

    // B-immediate: beq x0,x0,-4
    fe_drive(32'hFE000EE3, 32'h200, 1'b1);
    #1 chk("br_stall", ifc.stall_to_fe, 64'd0);
    tick();
    chk("br_oc", de.op_class, OC_BRANCH);
    chk("br_imm", de.imm, 64'hFFFFFFFC);
    chk("br_wr", de.wr_rd, 64'd0);

    // Mispredict while stalled: addi x7,x0,9 ; add x8,x7,x0 (flushed)
    fe_drive(32'h00900393, 32'h300, 1'b1);
    tick();
    chk("mp_p_valid", de.valid, 64'd1);
    fe_drive(32'h00038433, 32'h304, 1'b1);
    ifc.br_mispred_agex = 1'b1;
    #1 chk("mp_stall", ifc.stall_to_fe, 64'd1);
    tick();
    chk("mp_bubble", de.valid, 64'd0);
    ifc.br_mispred_agex = 1'b0;
    fe_drive(32'h0, 32'h308, 1'b0);
    wb(1'b1, 5'd7, 32'd9);
    tick();
    wb(1'b0, 5'd0, 32'h0);
    fe_drive(32'h007404B3, 32'h308, 1'b1);  // add x9,x8,x7
    #1 chk("mp_no_inc", ifc.stall_to_fe, 64'd0);
    tick();
    chk("mp_rs1", de.rs1_val, 64'd0);
    chk("mp_rs2", de.rs2_val, 64'd9);

    // Simultaneous inc/dec on x3
    fe_drive(32'h00100193, 32'h400, 1'b1);
    tick();
    fe_drive(32'h00200193, 32'h404, 1'b1);
    wb(1'b1, 5'd3, 32'd1);
    #1 chk("sim_stall", ifc.stall_to_fe, 64'd0);
    tick();
    chk("sim_imm", de.imm, 64'd2);
    wb(1'b0, 5'd0, 32'h0);
    fe_drive(32'h00018233, 32'h408, 1'b1);  // add x4,x3,x0
    #1 chk("sim_rd_stall", ifc.stall_to_fe, 64'd1);
    tick();
    chk("sim_bubble", de.valid, 64'd0);
    chk("sim_hold", ifc.stall_to_fe, 64'd1);

    // Reset mid-stream with x11 pending and a valid DE latch
    fe_drive(32'h00500593, 32'h500, 1'b1);  // addi x11,x0,5
    tick();
    chk("mr_valid", de.valid, 64'd1);
    fe_drive(32'h00B28633, 32'h504, 1'b1);  // add x12,x5,x11
    #1 chk("mr_stall", ifc.stall_to_fe, 64'd1);
    #2 reset = 1'b0;
    #1;
    chk("mr_latch", {63'd0, ifc.de_latch_out == '0}, 64'd1);
    chk("mr_stall0", ifc.stall_to_fe, 64'd0);
    #1 reset = 1'b1;
    #1 chk("mr_rel_stall", ifc.stall_to_fe, 64'd0);
    tick();
    chk("mr_issue", de.valid, 64'd1);
    chk("mr_rs1", de.rs1_val, 64'd0);
    chk("mr_pc", de.pc, 64'h504);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
